ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/ex_muldiv.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcode constants, FSM state encoding and iteration count for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int MULDIV_ITER = 32;
  localparam int CNT_W       = $clog2(MULDIV_ITER);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Two's-complement magnitude when neg is set, otherwise the value unchanged.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 step: shift-add multiply and, when MULDIV_DIV_EN is defined,
// restoring-divide trial subtract on the {hi, lo} working pair.
module muldiv_step (
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] m,
  output logic [31:0] mul_hi,
  output logic [31:0] mul_lo
`ifdef MULDIV_DIV_EN
  ,
  output logic [31:0] div_hi,
  output logic [31:0] div_lo
`endif
);

  logic [32:0] sum;

  // Multiply: lo holds the remaining multiplier bits, the partial product shifts right into it.
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'd0);
    mul_hi = sum[32:1];
    mul_lo = {sum[0], lo[31:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [32:0] shifted;
  logic        no_borrow;

  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    shifted   = {hi, lo[31]};
    no_borrow = (shifted >= {1'b0, m});
    div_hi    = no_borrow ? (shifted[31:0] - m) : shifted[31:0];
    div_lo    = {lo[30:0], no_borrow};
  end
`endif

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning the architectural HI/LO registers.
// The divide datapath is present only when MULDIV_DIV_EN is defined.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        EX_start,
  input  logic [2:0]  EX_op,
  input  logic [31:0] EX_opA,
  input  logic [31:0] EX_opB,
  input  logic        EX_flush,
  output logic        EX_busy,
  output logic        EX_done,
  output logic [31:0] EX_hi,
  output logic [31:0] EX_lo,
  output state_t      EX_state
);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      acc_hi, acc_hi_d, acc_lo, acc_lo_d, mcand, mcand_d;
  logic             is_div, is_div_d, neg_q, neg_q_d, neg_r, neg_r_d;
  logic [31:0]      hi_d, lo_d;
  logic             done_d;
  logic             sa, sb;
  logic [31:0]      mul_hi, mul_lo, step_hi, step_lo;

`ifdef MULDIV_DIV_EN
  logic [31:0] div_hi, div_lo;

  muldiv_step u_step (
    .hi     (acc_hi),
    .lo     (acc_lo),
    .m      (mcand),
    .mul_hi (mul_hi),
    .mul_lo (mul_lo),
    .div_hi (div_hi),
    .div_lo (div_lo)
  );

  assign step_hi = is_div ? div_hi : mul_hi;
  assign step_lo = is_div ? div_lo : mul_lo;
`else
  muldiv_step u_step (
    .hi     (acc_hi),
    .lo     (acc_lo),
    .m      (mcand),
    .mul_hi (mul_hi),
    .mul_lo (mul_lo)
  );

  assign step_hi = mul_hi;
  assign step_lo = mul_lo;
`endif

  // Odd opcodes are the unsigned forms, so op[0]=0 selects sign handling.
  assign sa       = ~EX_op[0] & EX_opA[31];
  assign sb       = ~EX_op[0] & EX_opB[31];
  assign EX_busy  = (state != ST_IDLE);
  assign EX_state = state;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    acc_hi_d = acc_hi;
    acc_lo_d = acc_lo;
    mcand_d  = mcand;
    is_div_d = is_div;
    neg_q_d  = neg_q;
    neg_r_d  = neg_r;
    hi_d     = EX_hi;
    lo_d     = EX_lo;
    done_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (EX_start && !EX_flush) begin
          case (EX_op)
            OP_MULT, OP_MULTU: begin
              state_d  = ST_RUN;
              cnt_d    = CNT_W'(MULDIV_ITER - 1);
              is_div_d = 1'b0;
              acc_hi_d = '0;
              acc_lo_d = mag32(EX_opB, sb);
              mcand_d  = mag32(EX_opA, sa);
              neg_q_d  = sa ^ sb;
              neg_r_d  = 1'b0;
            end
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU: begin
              state_d  = ST_RUN;
              cnt_d    = CNT_W'(MULDIV_ITER - 1);
              is_div_d = 1'b1;
              acc_hi_d = '0;
              acc_lo_d = mag32(EX_opA, sa);
              mcand_d  = mag32(EX_opB, sb);
              // A zero divisor leaves an all-ones quotient that must not be negated.
              neg_q_d  = (sa ^ sb) & (EX_opB != 32'd0);
              neg_r_d  = sa;
            end
`endif
            OP_MTHI: hi_d = EX_opA;
            OP_MTLO: lo_d = EX_opA;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (EX_flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt - 1'b1;
          if (cnt == '0) begin
            state_d = ST_FIX;
            cnt_d   = '0;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!EX_flush) begin
          done_d = 1'b1;
          if (is_div) begin
            lo_d = neg_q ? -acc_lo : acc_lo;
            hi_d = neg_r ? -acc_hi : acc_hi;
          end else begin
            {hi_d, lo_d} = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      EX_hi   <= '0;
      EX_lo   <= '0;
      EX_done <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      acc_hi  <= acc_hi_d;
      acc_lo  <= acc_lo_d;
      mcand   <= mcand_d;
      is_div  <= is_div_d;
      neg_q   <= neg_q_d;
      neg_r   <= neg_r_d;
      EX_hi   <= hi_d;
      EX_lo   <= lo_d;
      EX_done <= done_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: a scoreboard queue holds expected {HI,LO} per
// MULT/DIV issued and a monitor compares whenever EX_done pulses.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        CLOCK;
  logic        RESET;
  logic        EX_start;
  logic [2:0]  EX_op;
  logic [31:0] EX_opA;
  logic [31:0] EX_opB;
  logic        EX_flush;
  logic        EX_busy;
  logic        EX_done;
  logic [31:0] EX_hi;
  logic [31:0] EX_lo;
  state_t      EX_state;

  logic [63:0] exp_q[$];
  int          n_vec;
  int          n_err;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  ex_muldiv dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .EX_start (EX_start),
    .EX_op    (EX_op),
    .EX_opA   (EX_opA),
    .EX_opB   (EX_opB),
    .EX_flush (EX_flush),
    .EX_busy  (EX_busy),
    .EX_done  (EX_done),
    .EX_hi    (EX_hi),
    .EX_lo    (EX_lo),
    .EX_state (EX_state)
  );

  // Clock and reset
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every EX_done must match the oldest outstanding expectation.
  always @(negedge CLOCK) begin
    if (RESET && EX_done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(EX_done), 64'd0);
      end else begin
        check("hilo_result", {EX_hi, EX_lo}, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLOCK);
    EX_start = 1'b1;
    EX_op    = op;
    EX_opA   = a;
    EX_opB   = b;
    @(posedge CLOCK);
    #1 EX_start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK);
      if (!EX_busy) break;
      cycles++;
    end
    if (cycles >= 100) check("busy_timeout", 64'(cycles), 64'd33);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int c;
    exp_q.push_back({eh, el});
    issue(op, a, b);
    wait_idle(c);
    check("busy_len", 64'(c), 64'd33);
    cur_hi = eh;
    cur_lo = el;
  endtask

  task automatic run_ignored(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b);
    int c;
    issue(op, a, b);
    wait_idle(c);
    check({name, "_busy"}, 64'(c), 64'd0);
    @(negedge CLOCK);
    check({name, "_hilo"}, {EX_hi, EX_lo}, {cur_hi, cur_lo});
  endtask

  initial begin
    int c;
    n_vec    = 0;
    n_err    = 0;
    cur_hi   = '0;
    cur_lo   = '0;
    RESET    = 1'b0;
    EX_start = 1'b0;
    EX_op    = '0;
    EX_opA   = '0;
    EX_opB   = '0;
    EX_flush = 1'b0;
    #12;
    check("reset_outputs", {28'd0, EX_busy, EX_done, EX_state, EX_hi, EX_lo}, 64'd0);
    @(negedge CLOCK);
    RESET = 1'b1;

    // Signed multiply with latency and one-cycle done pulse
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    wait_idle(c);
    check("mult_busy_len", 64'(c), 64'd33);
    check("mult_done_at_33", 64'(EX_done), 64'd1);
    @(negedge CLOCK);
    check("mult_done_one_cycle", 64'(EX_done), 64'd0);
    cur_hi = 32'hFFFF_FFFF;
    cur_lo = 32'hFFFF_FFEB;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFB);
    run_op(OP_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780);

`ifdef MULDIV_DIV_EN
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(OP_DIVU, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op(OP_DIV,  32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
    run_op(OP_DIV,  32'hFFFF_FFFD, 32'd0,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999);
`else
    run_ignored("div_disabled",  OP_DIV,  32'hFFFF_FFF9, 32'd2);
    run_ignored("divu_disabled", OP_DIVU, 32'd100,       32'd0);
`endif

    run_ignored("reserved_op", 3'b110, 32'hDEAD_BEEF, 32'd3);

    // MTHI/MTLO write in one edge without busy or done
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    @(negedge CLOCK);
    cur_hi = 32'h1234_5678;
    check("mthi_write", {EX_hi, EX_lo, 30'd0, EX_busy, EX_done}, {cur_hi, cur_lo, 32'd0});
    issue(OP_MTLO, 32'h0F0F_0F0F, 32'd0);
    @(negedge CLOCK);
    cur_lo = 32'h0F0F_0F0F;
    check("mtlo_write", {EX_hi, EX_lo, 30'd0, EX_busy, EX_done}, {cur_hi, cur_lo, 32'd0});

    // A second start while busy is ignored
    exp_q.push_back({32'h0, 32'hC});
    issue(OP_MULT, 32'd3, 32'd4);
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK);
      if (!EX_busy) break;
      c++;
      if (c == 5) begin
        EX_start = 1'b1;
        EX_op    = OP_MULT;
        EX_opA   = 32'd5;
        EX_opB   = 32'd5;
      end else if (c == 6) begin
        EX_start = 1'b0;
      end
    end
    check("busy_start_len", 64'(c), 64'd33);
    cur_hi = 32'h0;
    cur_lo = 32'hC;
    repeat (3) @(negedge CLOCK);
    check("second_start_ignored", 64'(EX_busy), 64'd0);

    // Flush on the 10th RUN cycle
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (10) @(negedge CLOCK);
    EX_flush = 1'b1;
    @(posedge CLOCK);
    #1 EX_flush = 1'b0;
    @(negedge CLOCK);
    check("flush_run_busy", 64'(EX_busy), 64'd0);
    repeat (40) @(negedge CLOCK);
    check("flush_run_hilo", {EX_hi, EX_lo}, {cur_hi, cur_lo});

    // Flush in the FIX cycle blocks the HI/LO write
    issue(OP_MULT, 32'd9, 32'd9);
    repeat (33) @(negedge CLOCK);
    EX_flush = 1'b1;
    @(posedge CLOCK);
    #1 EX_flush = 1'b0;
    @(negedge CLOCK);
    check("flush_fix_busy", 64'(EX_busy), 64'd0);
    repeat (3) @(negedge CLOCK);
    check("flush_fix_hilo", {EX_hi, EX_lo}, {cur_hi, cur_lo});

    // Reset mid-operation
`ifdef MULDIV_DIV_EN
    issue(OP_DIV, 32'd1000, 32'd7);
`else
    issue(OP_MULT, 32'd1000, 32'd7);
`endif
    repeat (8) @(negedge CLOCK);
    #2 RESET = 1'b0;
    #1;
    check("reset_mid_op", {28'd0, EX_busy, EX_done, EX_state, EX_hi, EX_lo}, 64'd0);
    cur_hi = '0;
    cur_lo = '0;
    @(negedge CLOCK);
    RESET = 1'b1;
    repeat (40) @(negedge CLOCK);
    check("after_reset_idle", {30'd0, EX_busy, EX_done, EX_hi}, {32'd0, 32'd0});

    run_op(OP_MULT, 32'd6, 32'd7, 32'h0, 32'd42);

    repeat (3) @(negedge CLOCK);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
